// File: rtl/snn_pkg.sv
// ============================================================================
// Module : snn_pkg
// Brief  : Shared SNN readout types: FSM state encoding, default sizing,
//          and a saturating-increment helper for spike counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package snn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SCAN  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam int NUM_CLASSES_DEF = 10;
    localparam int COUNT_W_DEF     = 6;
    localparam int DIGIT_W_DEF     = 4;
    localparam int SAT_W           = 16;

    // Holds at max_val instead of wrapping; callers zero-extend into SAT_W.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                                 input logic [SAT_W-1:0] max_val);
        return (val >= max_val) ? val : val + SAT_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/spike_accum_bank.sv
// ============================================================================
// Module : spike_accum_bank
// Brief  : NUM_CLASSES saturating spike counters with clear/enable and an
//          indexed combinational read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spike_accum_bank
    import snn_pkg::*;
#(
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int COUNT_W     = COUNT_W_DEF,
    parameter int IDX_W       = DIGIT_W_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic                   en_i,
    input  logic [NUM_CLASSES-1:0] spike_i,
    input  logic [IDX_W-1:0]       rd_idx_i,
    output logic [COUNT_W-1:0]     rd_cnt_o
);

    localparam logic [SAT_W-1:0] C_CNT_MAX = SAT_W'({COUNT_W{1'b1}});

    logic [NUM_CLASSES-1:0][COUNT_W-1:0] cnt_q;
    logic [NUM_CLASSES-1:0][COUNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (clr_i) begin
                cnt_d[k] = '0;
            end else if (en_i && spike_i[k]) begin
                cnt_d[k] = COUNT_W'(sat_inc(SAT_W'(cnt_q[k]), C_CNT_MAX));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        rd_cnt_o = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (rd_idx_i == IDX_W'(k)) begin
                rd_cnt_o = cnt_q[k];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/spike_window_classifier.sv
// ============================================================================
// Module : spike_window_classifier
// Brief  : Accumulates output-layer spikes over a fixed window, scans for the
//          winning class and presents it on a valid/ready handshake.
//          Optional CLASSIFIER_MARGIN_EN adds margin_o (best minus runner-up).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spike_window_classifier
    import snn_pkg::*;
#(
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int COUNT_W     = COUNT_W_DEF,
    parameter int WINDOW_LEN  = 32,
    parameter int DIGIT_W     = DIGIT_W_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [NUM_CLASSES-1:0] spike_i,
    input  logic                   ready_i,
    output logic                   valid_o,
    output logic [DIGIT_W-1:0]     digit_o,
    output logic [COUNT_W-1:0]     count_o,
    output logic                   busy_o
`ifdef CLASSIFIER_MARGIN_EN
    ,
    output logic [COUNT_W-1:0]     margin_o
`endif
);

    localparam int                 STEP_W    = $clog2(WINDOW_LEN + 1);
    localparam logic [STEP_W-1:0]  C_LAST_ST = STEP_W'(WINDOW_LEN - 1);
    localparam logic [DIGIT_W-1:0] C_LAST_IX = DIGIT_W'(NUM_CLASSES - 1);

    state_t               state_q, state_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic [DIGIT_W-1:0]   idx_q, idx_d;
    logic [DIGIT_W-1:0]   best_idx_q, best_idx_d;
    logic [COUNT_W-1:0]   best_cnt_q, best_cnt_d;
    logic                 valid_q, valid_d;
    logic [DIGIT_W-1:0]   digit_q, digit_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 busy_q, busy_d;
    logic                 acc_clr, acc_en;
    logic [COUNT_W-1:0]   rd_cnt;
`ifdef CLASSIFIER_MARGIN_EN
    logic [COUNT_W-1:0]   second_q, second_d;
    logic [COUNT_W-1:0]   margin_q, margin_d;
`endif

    spike_accum_bank #(
        .NUM_CLASSES (NUM_CLASSES),
        .COUNT_W     (COUNT_W),
        .IDX_W       (DIGIT_W)
    ) u_bank (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (acc_clr),
        .en_i     (acc_en),
        .spike_i  (spike_i),
        .rd_idx_i (idx_q),
        .rd_cnt_o (rd_cnt)
    );

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        idx_d      = idx_q;
        best_idx_d = best_idx_q;
        best_cnt_d = best_cnt_q;
        valid_d    = valid_q;
        digit_d    = digit_q;
        count_d    = count_q;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
`ifdef CLASSIFIER_MARGIN_EN
        second_d   = second_q;
        margin_d   = margin_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    acc_clr = 1'b1;
                    step_d  = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                acc_en = 1'b1;
                step_d = step_q + STEP_W'(1);
                if (step_q == C_LAST_ST) begin
                    state_d    = ST_SCAN;
                    idx_d      = '0;
                    best_idx_d = '0;
                    best_cnt_d = '0;
`ifdef CLASSIFIER_MARGIN_EN
                    second_d   = '0;
`endif
                end
            end
            ST_SCAN: begin
                // Strict compare so ties keep the lower class index.
                if (rd_cnt > best_cnt_q) begin
                    best_idx_d = idx_q;
                    best_cnt_d = rd_cnt;
`ifdef CLASSIFIER_MARGIN_EN
                    second_d   = best_cnt_q;
                end else if (rd_cnt > second_q) begin
                    second_d   = rd_cnt;
`endif
                end
                idx_d = idx_q + DIGIT_W'(1);
                if (idx_q == C_LAST_IX) begin
                    digit_d = best_idx_d;
                    count_d = best_cnt_d;
`ifdef CLASSIFIER_MARGIN_EN
                    margin_d = best_cnt_d - second_d;
`endif
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_ACCUM) || (state_d == ST_SCAN);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
            valid_q    <= 1'b0;
            digit_q    <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
`ifdef CLASSIFIER_MARGIN_EN
            second_q   <= '0;
            margin_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            idx_q      <= idx_d;
            best_idx_q <= best_idx_d;
            best_cnt_q <= best_cnt_d;
            valid_q    <= valid_d;
            digit_q    <= digit_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
`ifdef CLASSIFIER_MARGIN_EN
            second_q   <= second_d;
            margin_q   <= margin_d;
`endif
        end
    end

    assign valid_o = valid_q;
    assign digit_o = digit_q;
    assign count_o = count_q;
    assign busy_o  = busy_q;
`ifdef CLASSIFIER_MARGIN_EN
    assign margin_o = margin_q;
`endif

endmodule

`default_nettype wire

// File: doc/spike_window_classifier.md
Name: spike_window_classifier

Overview:
Downstream readout stage for the output LIF layer. It takes the per-class output spike vector and accumulates saturating spike counts over a fixed inference window of timesteps. It then scans the counts sequentially to find the winning class and presents the predicted digit, with its count, on a valid/ready handshake. It replaces free-running count/argmax readout with a windowed, handshaked result.

Parameters:
NUM_CLASSES, 10, number of output neurons/classes (2..16)
COUNT_W, 6, width of each per-class saturating spike counter
WINDOW_LEN, 32, timesteps (clock cycles) accumulated per inference (1..2^16-1)
DIGIT_W, 4, width of class index output; must hold NUM_CLASSES-1

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
start_i  in  1  begin new inference window; honoured only in IDLE
spike_i  in  NUM_CLASSES  output-layer spike vector, bit k = class k
ready_i  in  1  consumer accepts result
valid_o  out  1  result held on digit_o/count_o
digit_o  out  DIGIT_W  predicted class index
count_o  out  COUNT_W  spike count of winning class
busy_o  out  1  high in ACCUM or SCAN

Behaviour:
- Reset (rst_i high at an edge): state IDLE; all counters, window step, scan index cleared. valid_o=0, digit_o=0, count_o=0, busy_o=0. Reset mid-window or mid-scan aborts; no result is produced.
- IDLE: when start_i=1 at edge E0, clear all counters and step=0, then go to ACCUM.
- ACCUM: at edges E1..E_WINDOW_LEN, sample spike_i. Each counter k increments by spike_i[k]. Counters saturate at 2^COUNT_W-1 with no wrap. After the sample at E_WINDOW_LEN, go to SCAN with idx=0, best_idx=0, best_cnt=0.
- SCAN: one class per cycle, NUM_CLASSES cycles. If cnt[idx] > best_cnt (strictly greater), update best. Ties keep the lower index. All-zero counts give digit 0, count 0. After idx=NUM_CLASSES-1, register best into digit_o/count_o and go to HOLD.
- Latency: valid_o rises after edge E0+WINDOW_LEN+NUM_CLASSES (42 edges at defaults).
- HOLD: valid_o=1; digit_o/count_o stable until handshake. Handshake completes at an edge with valid_o=1 and ready_i=1. Next cycle: valid_o=0, state IDLE. digit_o/count_o keep the last result until the next HOLD entry. ready_i may be high before valid_o; the handshake then completes on the first HOLD edge.
- start_i outside IDLE is ignored, including on the handshake edge. No queuing.
- spike_i is ignored outside ACCUM.
- busy_o=1 exactly in ACCUM and SCAN.
- Widths: step counter is clog2(WINDOW_LEN+1) bits. Counter compare is unsigned.

Optional Feature:
Macro CLASSIFIER_MARGIN_EN.
- Defined: extra output margin_o [COUNT_W] = best count minus the second-highest count across all classes, tracked during SCAN. A displaced best becomes the second. A tie with best sets the second equal to best, so margin 0. margin_o is reset to 0, registered with digit_o, and held in HOLD.
- Undefined: no margin_o port and no second-best logic.

Decomposition:
- Shared package snn_pkg holds: state enum (IDLE, ACCUM, SCAN, HOLD); default NUM_CLASSES/COUNT_W/DIGIT_W constants; a saturating-increment function reused by spike counters elsewhere.
- One natural sub-module, spike_accum_bank: NUM_CLASSES saturating counters with clear and enable inputs, and an indexed read port for SCAN.
- FSM, window step and argmax scan stay in the top.

Test Plan:
1. Reset then idle, no start → valid_o=0, busy_o=0, digit_o=0, count_o=0 for 100 cycles.
2. start_i pulse, spike_i=10'b0000001000 every cycle for 32 cycles → valid_o after 42 edges; digit_o=3, count_o=32. Hold ready_i=0 for 5 cycles → outputs stable. ready_i=1 → valid_o drops next cycle.
3. Classes 2 and 7 each spike 20 times, others 0 → digit_o=2, count_o=20 (tie picks lower). With CLASSIFIER_MARGIN_EN, margin_o=0.
4. WINDOW_LEN=100, class 5 spikes every cycle → count_o=63 (saturated), digit_o=5.
5. rst_i asserted at cycle 15 of ACCUM → no valid_o; a following start_i counts from zero. start_i pulses during SCAN/HOLD → ignored, exactly one result.
6. Class 9 = 12 spikes, class 4 = 9 spikes → digit_o=9, count_o=12. With CLASSIFIER_MARGIN_EN, margin_o=3.
